data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder end of the core's main-memory interface: owns the 256×16 data store the core's memory-access stage addresses, writes and reads. It adds a valid/ready host port for testbench or debug load/dump, arbitrated below core traffic. It also runs a power-on clear sweep, with `init_done` used at top level to hold the core in reset until memory is defined.

## Interface
- `DATA_WIDTH`, 16, word width
- `ADDR_WIDTH`, 8, address width; depth = 2^ADDR_WIDTH
- `INIT_VALUE`, 16'h0000, value written by the clear sweep
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low
- `address_from_core`  in  ADDR_WIDTH  core read/write address
- `data_from_core`  in  DATA_WIDTH  core write data
- `data_from_core_write_en`  in  1  core write strobe
- `data_to_core`  out  DATA_WIDTH  registered read data
- `host_req_valid`  in  1  host request present
- `host_req_ready`  out  1  host request accepted this cycle when valid&ready
- `host_req_write`  in  1  1 = write, 0 = read
- `host_req_address`  in  ADDR_WIDTH  host address
- `host_req_data`  in  DATA_WIDTH  host write data
- `host_rsp_valid`  out  1  one-cycle pulse carrying host read data
- `host_rsp_data`  out  DATA_WIDTH  host read data
- `init_done`  out  1  clear sweep complete; memory usable

## Operation
- FSM states: CLEAR, RUN. Reset enters CLEAR with sweep counter 0.
- CLEAR: writes INIT_VALUE to address = counter, one per cycle, counter+1 each cycle. After the write of the last address (2^ADDR_WIDTH−1), the FSM moves to RUN. The counter is ADDR_WIDTH+1 bits; terminal detection uses the MSB, with no wrap to 0.
- In CLEAR, core writes and host requests are ignored, `host_req_ready`=0, and `data_to_core` holds 0.
- RUN: the core reads every cycle at `address_from_core`. The core writes when `data_from_core_write_en`=1.
- Host `host_req_ready` = RUN && !`data_from_core_write_en`; the core always has priority.
- Accepted host write updates memory at that edge. Accepted host read produces `host_rsp_valid`=1 and data on the next cycle.
- Single write port. Per-edge write source priority: core write > accepted host write > clear sweep.
- Read-during-write, same address, same cycle: both readers (core and host) return the newly written data (write-first). A different address returns the stored value.
- Core write and host read to the same address in one cycle cannot occur, because ready=0 then.
- Reset asserted mid-sweep or mid-RUN:
  - outputs return to their reset values;
  - a pending host response is dropped;
  - the sweep restarts at 0.
- Array contents themselves are not reset.
- Reset values: `data_to_core`=0, `host_rsp_valid`=0, `host_rsp_data`=0, `init_done`=0, `host_req_ready`=0.

## Timing
- Core read latency 1: address at edge N → `data_to_core` valid after edge N+1, held until the next edge.
- Core write visible to a read issued the same cycle (forwarded) and to all later reads.
- Host read latency 1; `host_rsp_valid` is high exactly one cycle per accepted read. Back-to-back reads give back-to-back pulses. There is no response backpressure.
- Clear sweep takes 2^ADDR_WIDTH cycles. `init_done` rises at the edge after the last clear write (256 cycles after reset release with defaults) and stays high until reset.

## Configuration
- `DMEM_CLEAR_EN` defined: CLEAR state and sweep compiled in, as above.
- `DMEM_CLEAR_EN` undefined: no sweep counter, the FSM starts in RUN, and `init_done` rises at the first edge after reset release. Contents are undefined until written.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (CLEAR, RUN);
  - default DATA_WIDTH/ADDR_WIDTH/INIT_VALUE constants;
  - the write-source select enum (CORE, HOST, SWEEP).
- Sub-module `dmem_array` provides storage with one write port and two synchronous write-first read ports (core, host).
- FSM, arbitration and response register live in the top.

## Test plan
- Reset release with `DMEM_CLEAR_EN` → `init_done` high at cycle 256; host reads of 0x00, 0x7F, 0xFF all return 0x0000.
- Core writes 0xBEEF @0x10, reads 0x10 the same cycle → `data_to_core`=0xBEEF next cycle; a read at 0x11 returns 0x0000.
- Host write valid while core write_en=1 → `host_req_ready`=0; host write accepted the cycle after write_en drops; a core read then returns the host data.
- Host reads 0x20, 0x21 back-to-back after core wrote 0x1111/0x2222 → two consecutive `host_rsp_valid` pulses carrying 0x1111, 0x2222.
- Reset asserted at sweep count 100 and released → `init_done`=0 immediately; it rises 256 cycles after release; address 0xFF reads INIT_VALUE.
- Without `DMEM_CLEAR_EN` → `init_done` high one cycle after reset release; a core write/read of 0x1234 @0x05 round-trips with latency 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data memory responder and its storage array.
package dmem_pkg;

    localparam int              DMEM_DATA_WIDTH = 16;
    localparam int              DMEM_ADDR_WIDTH = 8;
    localparam logic [15:0]     DMEM_INIT_VALUE = 16'h0000;

    typedef enum logic {
        CLEAR,
        RUN
    } dmem_state_e;

    typedef enum logic [1:0] {
        CORE,
        HOST,
        SWEEP
    } dmem_wsel_e;

endpackage

// File: rtl/dmem_array.sv
// Single-write-port storage with two registered write-first read ports (core and host).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  core_rd_en,
    input  logic [ADDR_WIDTH-1:0] core_rd_addr,
    input  logic                  host_rd_en,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic [DATA_WIDTH-1:0] core_rd_data,
    output logic [DATA_WIDTH-1:0] host_rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] core_rd_data_q, core_rd_data_d;
    logic [DATA_WIDTH-1:0] host_rd_data_q, host_rd_data_d;

    // Same-address reads during a write see the incoming data (write-first).
    always_comb begin
        core_rd_data_d = core_rd_data_q;
        host_rd_data_d = host_rd_data_q;
        if (core_rd_en) begin
            core_rd_data_d = (wr_en && (wr_addr == core_rd_addr)) ? wr_data : mem_q[core_rd_addr];
        end
        if (host_rd_en) begin
            host_rd_data_d = (wr_en && (wr_addr == host_rd_addr)) ? wr_data : mem_q[host_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rd_data_q <= '0;
            host_rd_data_q <= '0;
        end else begin
            core_rd_data_q <= core_rd_data_d;
            host_rd_data_q <= host_rd_data_d;
        end
    end

    assign core_rd_data = core_rd_data_q;
    assign host_rd_data = host_rd_data_q;

endmodule

// File: rtl/data_memory_responder.sv
// Core-facing data memory with a lower-priority host load/dump port and power-on clear.
// Define DMEM_CLEAR_EN to compile in the clear sweep; otherwise memory is usable one edge after reset.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int                    DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(DMEM_INIT_VALUE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_from_core,
    input  logic [DATA_WIDTH-1:0] data_from_core,
    input  logic                  data_from_core_write_en,
    output logic [DATA_WIDTH-1:0] data_to_core,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic                  host_req_write,
    input  logic [ADDR_WIDTH-1:0] host_req_address,
    input  logic [DATA_WIDTH-1:0] host_req_data,
    output logic                  host_rsp_valid,
    output logic [DATA_WIDTH-1:0] host_rsp_data,
    output logic                  init_done
);

    dmem_state_e           state_q, state_d;
    logic                  init_done_q, init_done_d;
    logic                  host_rsp_valid_q, host_rsp_valid_d;
    logic                  active;
    logic                  host_accept;
    logic                  host_rd_accept;
    logic                  wr_en;
    dmem_wsel_e            wr_sel;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef DMEM_CLEAR_EN
    localparam dmem_state_e RESET_STATE = CLEAR;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    assign sweep_addr = cnt_q[ADDR_WIDTH-1:0];
`else
    localparam dmem_state_e RESET_STATE = RUN;
    assign sweep_addr = '0;
`endif

    // init_done gates activity so nothing is accepted while reset is held.
    assign active           = (state_q == RUN) && init_done_q;
    assign host_req_ready   = active && !data_from_core_write_en;
    assign host_accept      = host_req_valid && host_req_ready;
    assign host_rd_accept   = host_accept && !host_req_write;
    assign host_rsp_valid_d = host_rd_accept;

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
`ifdef DMEM_CLEAR_EN
        cnt_d       = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + (ADDR_WIDTH + 1)'(1);
            if (cnt_d[ADDR_WIDTH]) begin
                state_d = RUN;
            end
        end
`endif
        if (state_d == RUN) begin
            init_done_d = 1'b1;
        end
    end

    // Single write port: core beats host, host beats the clear sweep.
    always_comb begin
        wr_en  = 1'b0;
        wr_sel = SWEEP;
        if (active && data_from_core_write_en) begin
            wr_en  = 1'b1;
            wr_sel = CORE;
        end else if (host_accept && host_req_write) begin
            wr_en  = 1'b1;
            wr_sel = HOST;
        end
`ifdef DMEM_CLEAR_EN
        else if (state_q == CLEAR) begin
            wr_en  = 1'b1;
            wr_sel = SWEEP;
        end
`endif
        case (wr_sel)
            CORE: begin
                wr_addr = address_from_core;
                wr_data = data_from_core;
            end
            HOST: begin
                wr_addr = host_req_address;
                wr_data = host_req_data;
            end
            default: begin
                wr_addr = sweep_addr;
                wr_data = INIT_VALUE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= RESET_STATE;
            init_done_q      <= 1'b0;
            host_rsp_valid_q <= 1'b0;
`ifdef DMEM_CLEAR_EN
            cnt_q            <= '0;
`endif
        end else begin
            state_q          <= state_d;
            init_done_q      <= init_done_d;
            host_rsp_valid_q <= host_rsp_valid_d;
`ifdef DMEM_CLEAR_EN
            cnt_q            <= cnt_d;
`endif
        end
    end

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .core_rd_en   (active),
        .core_rd_addr (address_from_core),
        .host_rd_en   (host_rd_accept),
        .host_rd_addr (host_req_address),
        .core_rd_data (data_to_core),
        .host_rd_data (host_rsp_data)
    );

    assign init_done      = init_done_q;
    assign host_rsp_valid = host_rsp_valid_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder against an array-based memory model.
`timescale 1ns/1ps
module tb_data_memory_responder;

    localparam logic [15:0] INIT = 16'h0000;
`ifdef DMEM_CLEAR_EN
    localparam int INIT_CYCLES = 256;
`else
    localparam int INIT_CYCLES = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  address_from_core = '0;
    logic [15:0] data_from_core = '0;
    logic        data_from_core_write_en = 1'b0;
    logic [15:0] data_to_core;
    logic        host_req_valid = 1'b0;
    logic        host_req_ready;
    logic        host_req_write = 1'b0;
    logic [7:0]  host_req_address = '0;
    logic [15:0] host_req_data = '0;
    logic        host_rsp_valid;
    logic [15:0] host_rsp_data;
    logic        init_done;

    logic [15:0] model_mem [256];
    bit          model_known [256];
    int          checks = 0;
    int          fails = 0;

    data_memory_responder dut (
        .clk                     (clk),
        .reset                   (reset),
        .address_from_core       (address_from_core),
        .data_from_core          (data_from_core),
        .data_from_core_write_en (data_from_core_write_en),
        .data_to_core            (data_to_core),
        .host_req_valid          (host_req_valid),
        .host_req_ready          (host_req_ready),
        .host_req_write          (host_req_write),
        .host_req_address        (host_req_address),
        .host_req_data           (host_req_data),
        .host_rsp_valid          (host_rsp_valid),
        .host_rsp_data           (host_rsp_data),
        .init_done               (init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_forget_all();
        for (int i = 0; i < 256; i++) begin
            model_mem[i]   = 16'h0000;
            model_known[i] = 1'b0;
        end
    endtask

    task automatic model_cleared();
        for (int i = 0; i < 256; i++) begin
            model_mem[i]   = INIT;
            model_known[i] = 1'b1;
        end
    endtask

    task automatic core_write(input logic [7:0] a, input logic [15:0] d);
        data_from_core_write_en = 1'b1;
        address_from_core       = a;
        data_from_core          = d;
        tick();
        data_from_core_write_en = 1'b0;
        model_mem[a]   = d;
        model_known[a] = 1'b1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        host_req_valid = 1'b1;
        host_req_write = 1'b0;
        repeat (3) tick();
        checks++; if (data_to_core !== 16'h0000) begin fails++; $display("[TB] FAIL reset_data_to_core got %h want 0000", data_to_core); end
        checks++; if (host_rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid got %b want 0", host_rsp_valid); end
        checks++; if (host_rsp_data !== 16'h0000) begin fails++; $display("[TB] FAIL reset_rsp_data got %h want 0000", host_rsp_data); end
        checks++; if (init_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_init_done got %b want 0", init_done); end
        checks++; if (host_req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready got %b want 0", host_req_ready); end
        host_req_valid = 1'b0;
    endtask

    task automatic test_init();
        int n;
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
        reset = 1'b1;
        #1;
        checks++; if (host_req_ready !== 1'b0) begin fails++; $display("[TB] FAIL init_ready_early got %b want 0", host_req_ready); end
        wait_init(n);
        checks++; if (n != INIT_CYCLES) begin fails++; $display("[TB] FAIL init_cycles got %0d want %0d", n, INIT_CYCLES); end
        checks++; if (host_req_ready !== 1'b1) begin fails++; $display("[TB] FAIL init_ready_run got %b want 1", host_req_ready); end
`ifdef DMEM_CLEAR_EN
        model_cleared();
        foreach (addrs[k]) begin
            host_req_valid   = 1'b1;
            host_req_write   = 1'b0;
            host_req_address = addrs[k];
            tick();
            host_req_valid = 1'b0;
            checks++; if (host_rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL init_rsp_valid@%h got %b want 1", addrs[k], host_rsp_valid); end
            checks++; if (host_rsp_data !== INIT) begin fails++; $display("[TB] FAIL init_clear@%h got %h want %h", addrs[k], host_rsp_data, INIT); end
        end
`else
        model_forget_all();
`endif
    endtask

    task automatic test_core_forward();
`ifndef DMEM_CLEAR_EN
        core_write(8'h11, 16'h0000);
`endif
        data_from_core_write_en = 1'b1;
        address_from_core       = 8'h10;
        data_from_core          = 16'hBEEF;
        tick();
        data_from_core_write_en = 1'b0;
        model_mem[8'h10] = 16'hBEEF; model_known[8'h10] = 1'b1;
        checks++; if (data_to_core !== 16'hBEEF) begin fails++; $display("[TB] FAIL forward_same_cycle got %h want BEEF", data_to_core); end
        address_from_core = 8'h11;
        tick();
        checks++; if (data_to_core !== model_mem[8'h11]) begin fails++; $display("[TB] FAIL read_neighbor got %h want %h", data_to_core, model_mem[8'h11]); end
        core_write(8'h05, 16'h1234);
        checks++; if (data_to_core !== 16'h1234) begin fails++; $display("[TB] FAIL roundtrip_fwd got %h want 1234", data_to_core); end
        address_from_core = 8'h10;
        tick();
        checks++; if (data_to_core !== 16'hBEEF) begin fails++; $display("[TB] FAIL read_stored got %h want BEEF", data_to_core); end
        address_from_core = 8'h05;
        tick();
        checks++; if (data_to_core !== 16'h1234) begin fails++; $display("[TB] FAIL roundtrip_read got %h want 1234", data_to_core); end
    endtask

    task automatic test_priority();
        data_from_core_write_en = 1'b1;
        address_from_core       = 8'h30;
        data_from_core          = 16'hAAAA;
        host_req_valid          = 1'b1;
        host_req_write          = 1'b1;
        host_req_address        = 8'h31;
        host_req_data           = 16'h5555;
        #1;
        checks++; if (host_req_ready !== 1'b0) begin fails++; $display("[TB] FAIL prio_ready_blocked got %b want 0", host_req_ready); end
        tick();
        model_mem[8'h30] = 16'hAAAA; model_known[8'h30] = 1'b1;
        data_from_core_write_en = 1'b0;
        address_from_core       = 8'h31;
        #1;
        checks++; if (host_req_ready !== 1'b1) begin fails++; $display("[TB] FAIL prio_ready_free got %b want 1", host_req_ready); end
        tick();
        host_req_valid = 1'b0;
        model_mem[8'h31] = 16'h5555; model_known[8'h31] = 1'b1;
        checks++; if (data_to_core !== 16'h5555) begin fails++; $display("[TB] FAIL prio_host_fwd got %h want 5555", data_to_core); end
        checks++; if (host_rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL prio_no_rsp_on_write got %b want 0", host_rsp_valid); end
        address_from_core = 8'h30;
        tick();
        checks++; if (data_to_core !== 16'hAAAA) begin fails++; $display("[TB] FAIL prio_core_data got %h want AAAA", data_to_core); end
    endtask

    task automatic test_back_to_back();
        core_write(8'h20, 16'h1111);
        core_write(8'h21, 16'h2222);
        host_req_valid   = 1'b1;
        host_req_write   = 1'b0;
        host_req_address = 8'h20;
        tick();
        checks++; if (host_rsp_valid !== 1'b1 || host_rsp_data !== 16'h1111) begin fails++; $display("[TB] FAIL b2b_first got %b/%h want 1/1111", host_rsp_valid, host_rsp_data); end
        host_req_address = 8'h21;
        tick();
        host_req_valid = 1'b0;
        checks++; if (host_rsp_valid !== 1'b1 || host_rsp_data !== 16'h2222) begin fails++; $display("[TB] FAIL b2b_second got %b/%h want 1/2222", host_rsp_valid, host_rsp_data); end
        tick();
        checks++; if (host_rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_pulse_end got %b want 0", host_rsp_valid); end
    endtask

    task automatic test_random();
        logic [7:0]  ca, ha;
        logic [15:0] cd, hd, exp_core, exp_rsp_data;
        bit          cw, hv, hw, acc, exp_rsp, core_known, rsp_known;
        for (int i = 0; i < 300; i++) begin
            cw = ($urandom_range(0, 2) == 0);
            ca = 8'hC0 + 8'($urandom_range(0, 15));
            cd = 16'($urandom);
            hv = ($urandom_range(0, 1) == 1);
            hw = ($urandom_range(0, 1) == 1);
            ha = 8'hC0 + 8'($urandom_range(0, 15));
            hd = 16'($urandom);
            data_from_core_write_en = cw;
            address_from_core       = ca;
            data_from_core          = cd;
            host_req_valid          = hv;
            host_req_write          = hw;
            host_req_address        = ha;
            host_req_data           = hd;
            #1;
            checks++; if (host_req_ready !== (cw ? 1'b0 : 1'b1)) begin fails++; $display("[TB] FAIL rand_ready[%0d] got %b want %b", i, host_req_ready, !cw); end
            acc = hv && !cw;
            if (cw) begin model_mem[ca] = cd; model_known[ca] = 1'b1; end
            if (acc && hw) begin model_mem[ha] = hd; model_known[ha] = 1'b1; end
            exp_core     = model_mem[ca];
            core_known   = model_known[ca];
            exp_rsp      = acc && !hw;
            exp_rsp_data = model_mem[ha];
            rsp_known    = model_known[ha];
            tick();
            if (core_known) begin
                checks++; if (data_to_core !== exp_core) begin fails++; $display("[TB] FAIL rand_core[%0d]@%h got %h want %h", i, ca, data_to_core, exp_core); end
            end
            checks++; if (host_rsp_valid !== exp_rsp) begin fails++; $display("[TB] FAIL rand_rsp_valid[%0d] got %b want %b", i, host_rsp_valid, exp_rsp); end
            if (exp_rsp && rsp_known) begin
                checks++; if (host_rsp_data !== exp_rsp_data) begin fails++; $display("[TB] FAIL rand_rsp_data[%0d]@%h got %h want %h", i, ha, host_rsp_data, exp_rsp_data); end
            end
        end
        data_from_core_write_en = 1'b0;
        host_req_valid          = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int n;
        address_from_core = 8'h10;
        host_req_valid    = 1'b1;
        host_req_write    = 1'b0;
        host_req_address  = 8'h21;
        tick();
        host_req_valid = 1'b0;
        checks++; if (host_rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL midrun_pending got %b want 1", host_rsp_valid); end
        reset = 1'b0;
        #1;
        checks++; if (host_rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrun_rsp_drop got %b want 0", host_rsp_valid); end
        checks++; if (host_rsp_data !== 16'h0000) begin fails++; $display("[TB] FAIL midrun_rsp_data got %h want 0000", host_rsp_data); end
        checks++; if (data_to_core !== 16'h0000) begin fails++; $display("[TB] FAIL midrun_core_data got %h want 0000", data_to_core); end
        checks++; if (init_done !== 1'b0) begin fails++; $display("[TB] FAIL midrun_init_done got %b want 0", init_done); end
        tick();
        reset = 1'b1;
`ifdef DMEM_CLEAR_EN
        repeat (100) tick();
        reset = 1'b0;
        #1;
        checks++; if (init_done !== 1'b0) begin fails++; $display("[TB] FAIL midsweep_init_done got %b want 0", init_done); end
        tick();
        reset = 1'b1;
        model_cleared();
`endif
        wait_init(n);
        checks++; if (n != INIT_CYCLES) begin fails++; $display("[TB] FAIL restart_cycles got %0d want %0d", n, INIT_CYCLES); end
        host_req_valid   = 1'b1;
        host_req_address = 8'h10;
        tick();
        checks++; if (host_rsp_data !== model_mem[8'h10]) begin fails++; $display("[TB] FAIL restart_read10 got %h want %h", host_rsp_data, model_mem[8'h10]); end
        host_req_address = 8'hFF;
        tick();
        host_req_valid = 1'b0;
        if (model_known[8'hFF]) begin
            checks++; if (host_rsp_data !== model_mem[8'hFF]) begin fails++; $display("[TB] FAIL restart_readFF got %h want %h", host_rsp_data, model_mem[8'hFF]); end
        end
    endtask

    initial begin
        model_forget_all();
        test_reset();
        test_init();
        test_core_forward();
        test_priority();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
